// File: rtl/zuc_pkg.sv
// Shared ZUC definitions: word geometry, default keystream buffering, and the
// IDLE/RUN state encoding used by the EEA3 combiner.
package zuc_pkg;
  localparam int ZUC_WORD_W     = 32;
  // log2 of the word width: bit length >> ZUC_WORD_LG gives the whole-word count
  localparam int ZUC_WORD_LG    = 5;
  localparam int ZUC_FIFO_DEPTH = 8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} zuc_state_t;
endpackage

// File: rtl/zuc_eea3_xor_if.sv
// Data-in / data-out valid-ready handshakes of the EEA3 combiner.
interface zuc_eea3_xor_if;
  import zuc_pkg::*;

  logic                  pt_valid;
  logic                  pt_ready;
  logic [ZUC_WORD_W-1:0] pt_data;
  logic                  ct_valid;
  logic                  ct_ready;
  logic [ZUC_WORD_W-1:0] ct_data;
  logic                  ct_last;

  modport master (output pt_valid, pt_data, ct_ready,
                  input  pt_ready, ct_valid, ct_data, ct_last);
  modport slave  (input  pt_valid, pt_data, ct_ready,
                  output pt_ready, ct_valid, ct_data, ct_last);
endinterface

// File: rtl/zuc_ks_fifo.sv
// Keystream word buffer: wrap-bit pointers, head word visible the cycle after push.
module zuc_ks_fifo
  import zuc_pkg::*;
#(
  parameter int DEPTH = ZUC_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ZUC_WORD_W-1:0] wdata,
  output logic [ZUC_WORD_W-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr, rd_ptr;
  logic [ZUC_WORD_W-1:0] mem [DEPTH];
  logic                  do_push, do_pop;

  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  // a full FIFO may still take a word when the head leaves in the same cycle
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/zuc_eea3_xor.sv
// 128-EEA3 combiner: buffers ZUC keystream words and XORs them with message
// words, masking the final partial word to the message bit length.
module zuc_eea3_xor
  import zuc_pkg::*;
#(
  parameter int FIFO_DEPTH = ZUC_FIFO_DEPTH,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      bit_len,
  input  logic                  ks_valid,
  input  logic [ZUC_WORD_W-1:0] ks_word,
  zuc_eea3_xor_if.slave         bus,
  output logic                  busy,
  output logic                  overflow
);
  localparam int CW = LEN_W - ZUC_WORD_LG + 1;

  zuc_state_t             state, state_nxt;
  logic [CW-1:0]          cnt, n_words;
  logic [ZUC_WORD_LG-1:0] tail;
  logic                   go, done, last, flush, push, pop, full, empty;
  logic [ZUC_WORD_W-1:0]  ks_head, mask;

  assign go   = start && (bit_len != '0);
  assign done = bus.ct_valid && bus.ct_ready && bus.ct_last;
  assign last = cnt == n_words - CW'(1);
  assign busy = state == RUN;
  // keep the first `tail` message bits (MSB-first) of the closing word
  assign mask = (last && tail != '0) ? ~({ZUC_WORD_W{1'b1}} >> tail) : '1;

  zuc_ks_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (ks_word),
    .rdata (ks_head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    flush        = 1'b0;
    bus.pt_ready = 1'b0;
    push         = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_nxt = RUN;
        flush     = 1'b1;
      end
      RUN: begin
        bus.pt_ready = !empty && (cnt < n_words) && (!bus.ct_valid || bus.ct_ready);
        push         = ks_valid;
        if (done) begin
          state_nxt = IDLE;
          flush     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop = bus.pt_ready && bus.pt_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      n_words      <= '0;
      tail         <= '0;
      overflow     <= 1'b0;
      bus.ct_valid <= 1'b0;
      bus.ct_data  <= '0;
      bus.ct_last  <= 1'b0;
    end else begin
      if (state == IDLE && go) begin
        cnt      <= '0;
        n_words  <= {1'b0, bit_len[LEN_W-1:ZUC_WORD_LG]} + CW'(|bit_len[ZUC_WORD_LG-1:0]);
        tail     <= bit_len[ZUC_WORD_LG-1:0];
        overflow <= 1'b0;
      end
      if (push && full && !pop) overflow <= 1'b1;
      if (pop) begin
        bus.ct_valid <= 1'b1;
        bus.ct_data  <= (ks_head ^ bus.pt_data) & mask;
        bus.ct_last  <= last;
        cnt          <= cnt + CW'(1);
      end else if (bus.ct_ready) begin
        bus.ct_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_zuc_eea3_xor.sv
// Directed bench for zuc_eea3_xor with a queue-based reference model checked every cycle.
module tb_zuc_eea3_xor;
  localparam int DEPTH = 8;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] bit_len = '0;
  logic             ks_valid = 1'b0;
  logic [31:0]      ks_word = '0;
  logic             busy, overflow;

  zuc_eea3_xor_if bus();

  zuc_eea3_xor #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bit_len  (bit_len),
    .ks_valid (ks_valid),
    .ks_word  (ks_word),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tb_mask(input logic [31:0] x, input int r);
    logic [63:0] keep;
    if (r == 0) return x;
    keep = ((64'd1 << r) - 64'd1) << (32 - r);
    return x & keep[31:0];
  endfunction

  // reference model: message-level state plus a queue of stored keystream words
  bit          m_run = 0, m_ctv = 0, m_ctl = 0, m_ovf = 0;
  logic [31:0] m_ctd = '0;
  int          m_n = 0, m_r = 0, m_cnt = 0;
  logic [31:0] ks_q[$];
  logic [31:0] acc_d[$];
  bit          acc_l[$];

  always @(negedge clk) begin
    bit run_now, rdy, end_msg;
    logic [31:0] w;
    if (!rst_n) begin
      ks_q.delete();
      m_run = 0; m_ctv = 0; m_ctl = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      run_now = m_run;
      end_msg = 0;
      rdy = run_now && ks_q.size() > 0 && m_cnt < m_n && (!m_ctv || bus.ct_ready);
      chk("busy", busy, run_now);
      chk("pt_ready", bus.pt_ready, rdy);
      chk("ct_valid", bus.ct_valid, m_ctv);
      chk("overflow", overflow, m_ovf);
      if (m_ctv) begin
        chk("ct_data", bus.ct_data, m_ctd);
        chk("ct_last", bus.ct_last, m_ctl);
      end
      if (bus.ct_valid && bus.ct_ready) begin
        acc_d.push_back(bus.ct_data);
        acc_l.push_back(bus.ct_last);
      end
      if (m_ctv && bus.ct_ready) begin
        m_ctv = 0;
        if (m_ctl) end_msg = 1;
      end
      if (rdy && bus.pt_valid) begin
        w = ks_q.pop_front();
        m_ctl = (m_cnt == m_n - 1);
        m_ctd = tb_mask(w ^ bus.pt_data, m_ctl ? m_r : 0);
        m_ctv = 1;
        m_cnt++;
      end
      if (run_now && ks_valid) begin
        if (ks_q.size() < DEPTH) ks_q.push_back(ks_word);
        else m_ovf = 1;
      end
      if (end_msg) begin
        m_run = 0;
        ks_q.delete();
      end
      if (!run_now && start && bit_len != '0) begin
        m_run = 1; m_cnt = 0; m_ovf = 0;
        m_n = (int'(bit_len) + 31) / 32;
        m_r = int'(bit_len) % 32;
        ks_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    bit_len = LEN_W'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic ks_push(input logic [31:0] w);
    ks_valid = 1'b1;
    ks_word = w;
    tick();
    ks_valid = 1'b0;
  endtask

  task automatic pt_word(input logic [31:0] d);
    int n;
    n = 0;
    bus.pt_valid = 1'b1;
    bus.pt_data = d;
    @(negedge clk);
    while (!bus.pt_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("pt_accept_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic chk_word(input string nm, input int i, input logic [31:0] d, input bit l);
    if (i < acc_d.size()) begin
      chk($sformatf("%s_w%0d", nm, i), acc_d[i], d);
      chk($sformatf("%s_last%0d", nm, i), 32'(acc_l[i]), 32'(l));
    end else begin
      chk($sformatf("%s_missing%0d", nm, i), 32'd0, 32'd1);
    end
  endtask

  task automatic clr_acc();
    acc_d.delete();
    acc_l.delete();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_overflow"}, overflow, 0);
    chk({nm, "_pt_ready"}, bus.pt_ready, 0);
    chk({nm, "_ct_valid"}, bus.ct_valid, 0);
    chk({nm, "_ct_data"}, bus.ct_data, 0);
    chk({nm, "_ct_last"}, bus.ct_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.pt_valid = 1'b0;
    bus.pt_data = '0;
    bus.ct_ready = 1'b1;
    #12;
    chk_zero_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // 64-bit message, both words full
    clr_acc();
    do_start(64);
    ks_push(32'h12345678);
    ks_push(32'h9ABCDEF0);
    pt_word(32'hFFFFFFFF);
    pt_word(32'h00000000);
    bus.pt_valid = 1'b0;
    wait_idle();
    chk("t64_count", acc_d.size(), 2);
    chk_word("t64", 0, 32'hEDCBA987, 0);
    chk_word("t64", 1, 32'h9ABCDEF0, 1);

    // 40-bit message: last word keeps 8 bits
    clr_acc();
    do_start(40);
    ks_push(32'hA5A5A5A5);
    ks_push(32'h0F0F0F0F);
    pt_word(32'h00000000);
    pt_word(32'hFFFFFFFF);
    bus.pt_valid = 1'b0;
    wait_idle();
    chk("t40_count", acc_d.size(), 2);
    chk_word("t40", 0, 32'hA5A5A5A5, 0);
    chk_word("t40", 1, 32'hF0000000, 1);

    // 96-bit message with output stall
    clr_acc();
    bus.ct_ready = 1'b0;
    do_start(96);
    ks_push(32'h11111111);
    ks_push(32'h22222222);
    ks_push(32'h33333333);
    pt_word(32'h01020304);
    bus.pt_data = 32'h0A0B0C0D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.ct_valid, 1);
      chk("stall_data", bus.ct_data, 32'h10131215);
      chk("stall_pt_ready", bus.pt_ready, 0);
    end
    tick();
    bus.ct_ready = 1'b1;
    pt_word(32'h0A0B0C0D);
    pt_word(32'hF0F0F0F0);
    bus.pt_valid = 1'b0;
    wait_idle();
    chk("t96_count", acc_d.size(), 3);
    chk_word("t96", 0, 32'h10131215, 0);
    chk_word("t96", 1, 32'h28292E2F, 0);
    chk_word("t96", 2, 32'hC3C3C3C3, 1);
    chk("t96_overflow", overflow, 0);

    // nine words into an eight-deep buffer with nothing draining
    clr_acc();
    do_start(256);
    for (int i = 0; i < 9; i++) ks_push(32'h10000000 + 32'(i));
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 8; i++) pt_word(32'h0);
    bus.pt_valid = 1'b0;
    wait_idle();
    chk("ovf_count", acc_d.size(), 8);
    for (int i = 0; i < 8; i++) chk_word("ovf", i, 32'h10000000 + 32'(i), i == 7);
    chk("ovf_sticky", overflow, 1);

    // push into a full buffer in the same cycle as a pop
    clr_acc();
    do_start(288);
    chk("start_clears_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) ks_push(32'h20000000 + 32'(i));
    ks_valid = 1'b1;
    ks_word = 32'h20000008;
    bus.pt_valid = 1'b1;
    bus.pt_data = 32'h0;
    @(negedge clk);
    chk("full_pop_ready", bus.pt_ready, 1);
    tick();
    ks_valid = 1'b0;
    bus.pt_valid = 1'b0;
    chk("full_pop_no_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) pt_word(32'h0);
    bus.pt_valid = 1'b0;
    wait_idle();
    chk("fp_count", acc_d.size(), 9);
    chk_word("fp", 0, 32'h20000000, 0);
    chk_word("fp", 8, 32'h20000008, 1);
    chk("fp_overflow", overflow, 0);

    // asynchronous reset mid-message, then a single-word message
    clr_acc();
    do_start(128);
    for (int i = 0; i < 4; i++) ks_push(32'h30000000 + 32'(i));
    pt_word(32'h55555555);
    bus.pt_valid = 1'b0;
    tick();
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    clr_acc();
    do_start(32);
    ks_push(32'hCAFEBABE);
    pt_word(32'h0000FFFF);
    bus.pt_valid = 1'b0;
    wait_idle();
    chk("t32_count", acc_d.size(), 1);
    chk_word("t32", 0, 32'hCAFE4541, 1);

    // ignored events: zero-length start, keystream in IDLE, start during RUN
    clr_acc();
    do_start(0);
    tick();
    chk("len0_busy", busy, 0);
    for (int i = 0; i < 10; i++) ks_push(32'hDEAD0000 + 32'(i));
    chk("idle_ks_ovf", overflow, 0);
    chk("idle_ks_out", acc_d.size(), 0);
    do_start(64);
    ks_push(32'h01010101);
    chk("run_busy", busy, 1);
    do_start(32);
    ks_push(32'h02020202);
    pt_word(32'h10101010);
    pt_word(32'h20202020);
    bus.pt_valid = 1'b0;
    wait_idle();
    chk("ign_count", acc_d.size(), 2);
    chk_word("ign", 0, 32'h11111111, 0);
    chk_word("ign", 1, 32'h22222222, 1);
    chk("ign_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/zuc_eea3_xor.md
# zuc_eea3_xor

Keystream combiner that sits directly downstream of the ZUC keystream generator. It buffers the 32-bit keystream words, which the generator delivers as one-cycle `done` pulses with no backpressure. It XORs each buffered word with a plaintext/ciphertext word under valid/ready handshakes and masks the final partial word to the message bit length. The result is the 128-EEA3 confidentiality stream for one message per `start`.

## Interface
Parameters:
- FIFO_DEPTH, 8, keystream buffer entries; power of two, ≥2
- LEN_W, 16, width of message bit-length field

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches bit_len, begins a message
- bit_len  in  LEN_W  message length in bits; sampled on start
- ks_valid  in  1  keystream word strobe (generator `done`)
- ks_word  in  32  keystream word Z
- pt_valid  in  1  input data word valid
- pt_ready  out  1  input data word accepted when pt_valid & pt_ready
- pt_data  in  32  input data word, MSB = first message bit
- ct_valid  out  1  output word valid
- ct_ready  in  1  downstream accepts output word
- ct_data  out  32  pt_data XOR ks_word, last word masked
- ct_last  out  1  marks the final word of the message
- busy  out  1  high in RUN
- overflow  out  1  sticky; a keystream word was dropped

## Operation
- Word count is N = ceil(bit_len/32). The tail is R = bit_len mod 32.
- States:
  - IDLE: start with bit_len≠0 goes to RUN, flushes the FIFO, clears overflow and the word counter, and latches N and R. start with bit_len=0 is ignored. ks_valid in IDLE is dropped silently, without setting overflow.
  - RUN: the FIFO pushes on ks_valid. A word pair fires when the FIFO is non-empty, pt_valid is high, the counter is below N, and the output register is empty or ct_ready is high. Firing pops the FIFO, loads the output register, and increments the counter.
  - RUN exit: when the word flagged ct_last is accepted (ct_valid & ct_ready & ct_last), go to IDLE and flush the FIFO. Surplus keystream words are discarded.
- pt_ready = RUN & FIFO non-empty & counter<N & (!ct_valid | ct_ready). It is combinational from state, FIFO and ct_ready.
- Last-word mask: when counter = N-1 and R≠0, keep bits [31:32-R] of the XOR and zero the rest. When R=0 the word is unmasked.
- Full FIFO:
  - ks_valid with no pop in the same cycle drops the word and sets overflow=1 (sticky until the next accepted start).
  - Push and pop in the same cycle while full is legal and does not overflow.
- start while in RUN is ignored.
- Output register holds ct_data, ct_last and ct_valid stable while ct_valid & !ct_ready.
- Arithmetic: the counter is LEN_W-5+1 bits wide and cannot wrap for a legal bit_len.

## Timing
- Reset values: pt_ready=0, ct_valid=0, ct_data=0, ct_last=0, busy=0, overflow=0. The FIFO is empty and the state is IDLE.
- Asynchronous reset mid-message aborts immediately. Nothing is retained.
- start at cycle t: busy=1 at t+1. A ks_valid at t+1 is the first word stored.
- Keystream push to pop-eligible: 1 cycle (the FIFO output is registered-read, not fall-through).
- pt accept to ct_valid: 1 cycle.
- Full throughput is one word per cycle when ks, pt and ct_ready are all continuously available.
- ct_last handshake at cycle t: busy=0 at t+1. A new start is accepted from t+1.

## Structure
- Shared package zuc_pkg holds:
  - ZUC_WORD_W = 32
  - FIFO_DEPTH default
  - the state enum (IDLE, RUN) used by this block
  - the word-count helper constant shared with the generator's L handling
- Sub-module zuc_ks_fifo is a synchronous FIFO parameterised by depth. It has push/pop/full/empty and async active-low reset. It holds pointers plus a count bit, and supports same-cycle push/pop while full.
- The top level contains the FSM, the counter, the mask logic and the output register.

## Test plan
- bit_len=64; ks 0x12345678, 0x9ABCDEF0; pt 0xFFFFFFFF, 0x00000000 → ct 0xEDCBA987, then 0x9ABCDEF0 with ct_last=1. busy drops the cycle after.
- bit_len=40; ks 0xA5A5A5A5, 0x0F0F0F0F; pt 0x00000000, 0xFFFFFFFF → ct 0xA5A5A5A5, then 0xF0000000 with ct_last.
- bit_len=96; hold ct_ready=0 for 5 cycles after the first ct_valid → ct_data stable, pt_ready=0 throughout, all 3 words correct afterwards, overflow=0.
- FIFO_DEPTH=8; 9 ks_valid pulses with pt_valid=0 → overflow=1. The first 8 words XOR correctly and the 9th is absent. A push on the full FIFO in the same cycle as a pop does not set overflow.
- Assert rst_n low mid-message (after word 1 of 4) → all outputs 0 asynchronously. A subsequent start with bit_len=32 completes normally with a single ct_last word.
- start with bit_len=0, start during RUN, and ks_valid in IDLE → all ignored: state unchanged, no ct output, overflow=0.
